conv_scan_ctrl: RTL and testbench
=================================

// Module: conv_scan_ctrl
// PURPOSE
//  Upstream sequencer for the 16-lane weight register array. On start, fetches one 3x3 kernel
//  from the 16 weight banks (all lanes in parallel). It then walks the kernel/output-position
//  loop nest (x,y inner, X,Y outer) and issues the load and shift strobes the weight cells act on.
//  It raises finish after the last output position.
// PARAMETERS
//  KSIZE   3   kernel edge; x,y count 0..KSIZE-1
//  OSIZE   19  output map edge; X,Y count 0..OSIZE-1
//  AW      4   weight bank address width (KSIZE*KSIZE <= 2**AW)
//  RD_LAT  1   weight bank read latency in cycles (raddr -> rdata valid)
// PORTS
//  clk        in   1   clock, rising edge
//  xrst       in   1   reset, asynchronous, active-low
//  start      in   1   1-cycle request; accepted only in IDLE
//  stall      in   1   downstream back-pressure; freezes SCAN
//  raddr      out  AW  weight bank read address, broadcast to all 16 banks
//  wload_en   out  1   rdata valid this cycle; weight cells capture into slot wload_idx
//  wload_idx  out  AW  kernel slot for the current rdata (= ky*KSIZE+kx)
//  x,y        out  2   kernel column/row counters
//  X,Y        out  5   output column/row counters
//  x_adv      out  1   last step incremented x only (shift to right neighbour)
//  y_adv      out  1   last step wrapped x and incremented y (shift to lower neighbour)
//  X_adv      out  1   last step wrapped x,y and incremented X
//  row_wrap   out  1   last step wrapped X (X 18->0): return weights to row origin
//  busy       out  1   high in LOAD and SCAN
//  finish     out  1   1-cycle pulse when the scan completes
// BEHAVIOUR
//  - Reset: state IDLE; every output is 0. The reset is async and valid mid-operation; it aborts
//    the run with no finish pulse.
//  - All outputs are registered. The FSM states are IDLE -> LOAD -> SCAN -> DONE -> IDLE.
//  - IDLE: on start=1, go to LOAD with raddr=0 and busy=1 on the next cycle.
//  - LOAD: raddr steps 0..KSIZE*KSIZE-1, one value per cycle, and ignores stall.
//    wload_en/wload_idx are the raddr issue strobe/value delayed RD_LAT cycles.
//    There are exactly 9 wload_en pulses, with idx 0..8 in order.
//  - LOAD -> SCAN on the cycle after the final wload_en. In that cycle all counters are 0 and
//    all strobes are 0. raddr returns to 0 once issue ends.
//  - SCAN step: a step occurs on each cycle with stall=0. At the next edge x increments.
//    x==KSIZE-1 -> x=0, y++. Then y==KSIZE-1 -> y=0, X++. Then X==OSIZE-1 -> X=0, Y++.
//  - The strobes are valid in the cycle the new counter values appear and are mutually
//    exclusive. On the final step only finish rises.
//  - stall=1: counters hold and all strobes are 0 in the following cycle. stall has no effect
//    outside SCAN.
//  - Final step from (x,y,X,Y) = (2,2,18,18) with stall=0: go to DONE. Counters clear to 0,
//    finish=1 for one cycle, busy=0, then IDLE.
//  - With no stall, the run takes 9 load cycles plus the RD_LAT drain, then 9*19*19 = 3249
//    scan steps.
//  - start while busy or in DONE is ignored. A start in the finish cycle is ignored.
//  - Widths: the counters are unsigned and no arithmetic leaves its counter width.
//    wload_idx is zero-extended.
// STRUCTURE
//  - Shared package conv_pkg: KSIZE, OSIZE, AW, RD_LAT, KW=2, OW=5, NLANE=16,
//    and the state enum {IDLE, LOAD, SCAN, DONE}.
//  - Sub-module scan_counter #(MAX, W): ports clk, xrst, en, clr -> q, at_max.
//    It wraps to 0 at MAX with en. There are four instances, chained by at_max & en.
//  - The RD_LAT delay line for wload_en/wload_idx is a local shift register.
// TESTING
//  1 Reset during SCAN at (1,0,5,3) -> next cycle all outputs 0; no finish;
//    a fresh start gives a full run.
//  2 start with stall=0 -> raddr 0..8 on consecutive cycles; wload_en 9 pulses lagging by 1
//    with idx 0..8; finish after exactly 3249 scan steps; x_adv count 2166, y_adv count 722,
//    X_adv count 342, row_wrap count 18.
//  3 stall=1 for 4 cycles at (2,2,17,0) -> counters frozen, strobes 0; on release
//    X_adv=1 with (0,0,18,0).
//  4 Step from (2,2,18,4) -> row_wrap=1 only, with counters (0,0,0,5).
//  5 start pulses mid-LOAD, mid-SCAN, and in the finish cycle -> no restart and no
//    raddr disturbance.
//  6 RD_LAT=2 build -> wload_en lags raddr by 2; SCAN entered on the cycle after idx 8.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the convolution scan sequencer.
package conv_pkg;

    localparam int KSIZE  = 3;   // kernel edge
    localparam int OSIZE  = 19;  // output map edge
    localparam int AW     = 4;   // weight bank address width
    localparam int RD_LAT = 1;   // weight bank read latency
    localparam int KW     = 2;   // kernel counter width
    localparam int OW     = 5;   // output counter width
    localparam int NLANE  = 16;  // weight lanes fed in parallel

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

endpackage

// File: rtl/conv_scan_ctrl_scan_counter.sv
// Wrap-around loop counter: counts 0..MAX on en, returns to 0 after MAX.
module scan_counter #(
    parameter int MAX = 2,
    parameter int W   = 2
)(
    input  logic         clk,
    input  logic         xrst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         at_max
);

    assign at_max = (q == W'(MAX));

    // Count register: clear has priority, wrap to zero at MAX.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= at_max ? '0 : q + W'(1);
        end
    end

endmodule

// File: rtl/conv_scan_ctrl.sv
// Kernel fetch and output-position scan sequencer for the weight register array.
// Fetches one kernel from the weight banks, then walks x,y (inner) and X,Y (outer)
// issuing shift strobes; pulses finish after the last output position.
module conv_scan_ctrl
    import conv_pkg::*;
#(
    parameter int RD_LAT_CFG = RD_LAT
)(
    input  logic          clk,
    input  logic          xrst,
    input  logic          start,
    input  logic          stall,
    output logic [AW-1:0] raddr,
    output logic          wload_en,
    output logic [AW-1:0] wload_idx,
    output logic [KW-1:0] x,
    output logic [KW-1:0] y,
    output logic [OW-1:0] X,
    output logic [OW-1:0] Y,
    output logic          x_adv,
    output logic          y_adv,
    output logic          X_adv,
    output logic          row_wrap,
    output logic          busy,
    output logic          finish
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(KSIZE*KSIZE-1);

    state_t        state, state_nxt;
    logic          iss, iss_nxt;
    logic [AW-1:0] raddr_nxt;
    logic          fin_nxt;
    logic          cnt_clr;
    logic          step;
    logic          x_max, y_max, X_max, Y_max;
    logic          en_y, en_X, en_Y;

    // Read-latency delay line carrying the issue strobe and address to the cells.
    logic [RD_LAT_CFG-1:0] vld_pipe;
    logic [AW-1:0]         idx_pipe [RD_LAT_CFG];

    assign step = (state == SCAN) && !stall;
    assign en_y = step & x_max;
    assign en_X = en_y & y_max;
    assign en_Y = en_X & X_max;

    assign wload_en  = vld_pipe[RD_LAT_CFG-1];
    assign wload_idx = idx_pipe[RD_LAT_CFG-1];

    // State register.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nxt = state;
        iss_nxt   = 1'b0;
        raddr_nxt = '0;
        fin_nxt   = 1'b0;
        cnt_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                    iss_nxt   = 1'b1;
                    cnt_clr   = 1'b1;
                end
            end
            LOAD: begin
                if (iss && raddr != LAST_ADDR) begin
                    iss_nxt   = 1'b1;
                    raddr_nxt = raddr + AW'(1);
                end
                // Leave only once the last fetched weight has been handed over.
                if (wload_en && wload_idx == LAST_ADDR) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (step && x_max && y_max && X_max && Y_max) begin
                    state_nxt = DONE;
                    fin_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs: fetch address, status and mutually exclusive step strobes.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            raddr    <= '0;
            iss      <= 1'b0;
            busy     <= 1'b0;
            finish   <= 1'b0;
            x_adv    <= 1'b0;
            y_adv    <= 1'b0;
            X_adv    <= 1'b0;
            row_wrap <= 1'b0;
        end else begin
            raddr    <= raddr_nxt;
            iss      <= iss_nxt;
            busy     <= (state_nxt == LOAD) || (state_nxt == SCAN);
            finish   <= fin_nxt;
            x_adv    <= step & !x_max;
            y_adv    <= step & x_max & !y_max;
            X_adv    <= step & x_max & y_max & !X_max;
            row_wrap <= step & x_max & y_max & X_max & !Y_max;
        end
    end

    // Shift the issue strobe/address through RD_LAT_CFG stages.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            vld_pipe <= '0;
            for (int i = 0; i < RD_LAT_CFG; i++) begin
                idx_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0] <= iss;
            idx_pipe[0] <= raddr;
            for (int i = 1; i < RD_LAT_CFG; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
            end
        end
    end

    scan_counter #(.MAX(KSIZE-1), .W(KW)) u_cnt_x (
        .clk(clk), .xrst(xrst), .en(step), .clr(cnt_clr), .q(x), .at_max(x_max)
    );

    scan_counter #(.MAX(KSIZE-1), .W(KW)) u_cnt_y (
        .clk(clk), .xrst(xrst), .en(en_y), .clr(cnt_clr), .q(y), .at_max(y_max)
    );

    scan_counter #(.MAX(OSIZE-1), .W(OW)) u_cnt_bx (
        .clk(clk), .xrst(xrst), .en(en_X), .clr(cnt_clr), .q(X), .at_max(X_max)
    );

    scan_counter #(.MAX(OSIZE-1), .W(OW)) u_cnt_by (
        .clk(clk), .xrst(xrst), .en(en_Y), .clr(cnt_clr), .q(Y), .at_max(Y_max)
    );

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Bench for conv_scan_ctrl: per-cycle scoreboard against a linear-index model,
// plus directed checks of stall, wrap, reset abort and a read-latency-2 build.
module tb_conv_scan_ctrl;
    import conv_pkg::*;

    logic clk = 1'b0;
    logic xrst, start, stall, stall2;

    logic [AW-1:0] d1_raddr, d1_wload_idx, d2_raddr, d2_wload_idx;
    logic          d1_wload_en, d2_wload_en;
    logic [KW-1:0] d1_x, d1_y, d2_x, d2_y;
    logic [OW-1:0] d1_X, d1_Y, d2_X, d2_Y;
    logic d1_x_adv, d1_y_adv, d1_X_adv, d1_row_wrap, d1_busy, d1_finish;
    logic d2_x_adv, d2_y_adv, d2_X_adv, d2_row_wrap, d2_busy, d2_finish;

    int errors = 0;
    int checks = 0;

    int m_mode = 0;   // 0 idle, 1 load, 2 scan, 3 done
    int m_k    = 0;   // cycle index within LOAD
    int m_lin  = 0;   // linear scan position 0..3248
    logic [31:0] exp_q [$];

    int n_xa, n_ya, n_bxa, n_rw, n_fin;

    always #5 clk = ~clk;

    conv_scan_ctrl dut1 (
        .clk(clk), .xrst(xrst), .start(start), .stall(stall),
        .raddr(d1_raddr), .wload_en(d1_wload_en), .wload_idx(d1_wload_idx),
        .x(d1_x), .y(d1_y), .X(d1_X), .Y(d1_Y),
        .x_adv(d1_x_adv), .y_adv(d1_y_adv), .X_adv(d1_X_adv), .row_wrap(d1_row_wrap),
        .busy(d1_busy), .finish(d1_finish)
    );

    conv_scan_ctrl #(.RD_LAT_CFG(2)) dut2 (
        .clk(clk), .xrst(xrst), .start(start), .stall(stall2),
        .raddr(d2_raddr), .wload_en(d2_wload_en), .wload_idx(d2_wload_idx),
        .x(d2_x), .y(d2_y), .X(d2_X), .Y(d2_Y),
        .x_adv(d2_x_adv), .y_adv(d2_y_adv), .X_adv(d2_X_adv), .row_wrap(d2_row_wrap),
        .busy(d2_busy), .finish(d2_finish)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int ra, wen, wi, cx, cy, cX, cY,
                                         xa, ya, bxa, rw, bsy, fin);
        return {3'b0, ra[3:0], wen[0], wi[3:0], cx[1:0], cy[1:0], cX[4:0], cY[4:0],
                xa[0], ya[0], bxa[0], rw[0], bsy[0], fin[0]};
    endfunction

    function automatic logic [31:0] obs1();
        return {3'b0, d1_raddr, d1_wload_en, d1_wload_idx, d1_x, d1_y, d1_X, d1_Y,
                d1_x_adv, d1_y_adv, d1_X_adv, d1_row_wrap, d1_busy, d1_finish};
    endfunction

    function automatic logic [31:0] obs2();
        return {3'b0, d2_raddr, d2_wload_en, d2_wload_idx, d2_x, d2_y, d2_X, d2_Y,
                d2_x_adv, d2_y_adv, d2_X_adv, d2_row_wrap, d2_busy, d2_finish};
    endfunction

    // Advance the reference model by one clock edge and queue the expected outputs.
    task automatic model_step(input logic st, input logic sl);
        int ra = 0, wen = 0, wi = 0, bsy = 0, fin = 0;
        int xa = 0, ya = 0, bxa = 0, rw = 0;
        int cx = 0, cy = 0, cX = 0, cY = 0;
        case (m_mode)
            0: if (st) begin m_mode = 1; m_k = 0; bsy = 1; end
            1: begin
                bsy = 1;
                if (m_k == 9) begin
                    m_mode = 2; m_lin = 0;
                end else begin
                    m_k++;
                    ra = (m_k <= 8) ? m_k : 0;
                    wen = 1; wi = m_k - 1;
                end
            end
            2: begin
                if (!sl) begin
                    if (m_lin == 3248) begin
                        m_mode = 3; fin = 1;
                    end else begin
                        m_lin++;
                        if (m_lin % 3 != 0) xa = 1;
                        else if ((m_lin / 3) % 3 != 0) ya = 1;
                        else if ((m_lin / 9) % 19 != 0) bxa = 1;
                        else rw = 1;
                    end
                end
                if (m_mode == 2) begin
                    bsy = 1;
                    cx = m_lin % 3; cy = (m_lin / 3) % 3;
                    cX = (m_lin / 9) % 19; cY = m_lin / 171;
                end
            end
            default: m_mode = 0;
        endcase
        exp_q.push_back(pack(ra, wen, wi, cx, cy, cX, cY, xa, ya, bxa, rw, bsy, fin));
    endtask

    // One clock: drive inputs, model the edge, compare at the falling edge.
    task automatic cyc(input logic st, input logic sl);
        logic [31:0] e;
        start = st;
        stall = sl;
        @(posedge clk);
        model_step(st, sl);
        @(negedge clk);
        e = exp_q.pop_front();
        check("cycle_vec", obs1(), e);
        if (d1_x_adv)    n_xa++;
        if (d1_y_adv)    n_ya++;
        if (d1_X_adv)    n_bxa++;
        if (d1_row_wrap) n_rw++;
        if (d1_finish)   n_fin++;
    endtask

    task automatic clear_counts();
        n_xa = 0; n_ya = 0; n_bxa = 0; n_rw = 0; n_fin = 0;
    endtask

    initial begin
        int r, f1, f2;
        xrst = 1'b0; start = 1'b0; stall = 1'b0; stall2 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_d1", obs1(), 32'd0);
        check("reset_d2", obs2(), 32'd0);
        xrst = 1'b1;
        cyc(1'b0, 1'b0);

        // Full run, start pulses mid-LOAD, mid-SCAN and in the finish cycle.
        clear_counts();
        f1 = -1; f2 = -1;
        cyc(1'b1, 1'b0);
        r = 1;
        for (int i = 0; i < 3400; i++) begin
            if (r <= 13) begin
                check("d2_raddr", 32'(d2_raddr), (r <= 9) ? r - 1 : 0);
                check("d2_wload_en", 32'(d2_wload_en), 32'(r >= 3 && r <= 11));
                if (r >= 3 && r <= 11) check("d2_wload_idx", 32'(d2_wload_idx), r - 3);
                if (r == 12) check("d2_scan_entry", obs2(), pack(0,0,0,0,0,0,0,0,0,0,0,1,0));
                if (r == 13) check("d2_first_step", 32'({d2_x, d2_x_adv}), 32'({2'd1, 1'b1}));
            end
            if (d1_finish && f1 < 0) f1 = r;
            if (d2_finish && f2 < 0) f2 = r;
            if (r >= 3266) break;
            cyc((r == 4) || (r == 99) || (m_mode == 3), 1'b0);
            r++;
        end
        check("d1_finish_cycle", f1, 3260);
        check("d2_finish_cycle", f2, 3261);
        check("finish_pulses", n_fin, 1);
        check("x_adv_count", n_xa, 2166);
        check("y_adv_count", n_ya, 722);
        check("X_adv_count", n_bxa, 342);
        check("row_wrap_count", n_rw, 18);
        check("idle_after_run", 32'(d1_busy), 32'd0);

        // Stall at (2,2,17,0), then reset abort at (1,0,5,3).
        clear_counts();
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 400 && !(m_mode == 2 && m_lin == 161); i++) cyc(1'b0, 1'b0);
        check("pos_2_2_17_0", 32'({d1_x, d1_y, d1_X, d1_Y}), 32'({2'd2, 2'd2, 5'd17, 5'd0}));
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1);
            check("stall_hold", 32'({d1_x, d1_y, d1_X, d1_Y, d1_x_adv, d1_y_adv, d1_X_adv, d1_row_wrap}),
                  32'({2'd2, 2'd2, 5'd17, 5'd0, 4'b0000}));
        end
        cyc(1'b0, 1'b0);
        check("stall_release", 32'({d1_x, d1_y, d1_X, d1_Y, d1_x_adv, d1_y_adv, d1_X_adv, d1_row_wrap}),
              32'({2'd0, 2'd0, 5'd18, 5'd0, 4'b0010}));
        for (int i = 0; i < 600 && !(m_mode == 2 && m_lin == 559); i++) cyc(1'b0, 1'b0);
        check("pos_1_0_5_3", 32'({d1_x, d1_y, d1_X, d1_Y}), 32'({2'd1, 2'd0, 5'd5, 5'd3}));
        #2 xrst = 1'b0;
        #1 check("async_reset", obs1(), 32'd0);
        m_mode = 0;
        exp_q.delete();
        @(negedge clk);
        check("reset_hold", obs1(), 32'd0);
        check("no_finish_on_abort", n_fin, 0);
        xrst = 1'b1;

        // Fresh run after abort: wrap step at (2,2,18,4) and completion.
        clear_counts();
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 1000 && !(m_mode == 2 && m_lin == 854); i++) cyc(1'b0, 1'b0);
        check("pos_2_2_18_4", 32'({d1_x, d1_y, d1_X, d1_Y}), 32'({2'd2, 2'd2, 5'd18, 5'd4}));
        cyc(1'b0, 1'b0);
        check("row_wrap_step", 32'({d1_x, d1_y, d1_X, d1_Y, d1_x_adv, d1_y_adv, d1_X_adv, d1_row_wrap}),
              32'({2'd0, 2'd0, 5'd0, 5'd5, 4'b0001}));
        for (int i = 0; i < 3000 && n_fin == 0; i++) cyc(1'b0, 1'b0);
        check("fresh_run_finish", n_fin, 1);
        check("fresh_finish_busy", 32'({d1_busy, d1_x, d1_y, d1_X, d1_Y}), 32'd0);
        cyc(1'b0, 1'b0);
        check("fresh_idle", 32'({d1_busy, d1_finish}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
